// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder front-end: width helper, default sizes,
// and the dispatcher FSM encoding.
package reorder_pkg;

  // Ceiling log2, never less than 1 so single-entry sizes still get a bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned NUM_REQ_D    = 4;
  localparam int unsigned NUM_QUEUES_D = 4;
  localparam int unsigned DEPTH_D      = 64;
  localparam int unsigned MAX_SEG_D    = 4;

  localparam int unsigned DEF_SEL_W = clog2(NUM_QUEUES_D);
  localparam int unsigned DEF_ID_W  = clog2(DEPTH_D);
  localparam int unsigned DEF_LEN_W = clog2(MAX_SEG_D);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/reorder_trace_dispatcher_if.sv
// Request, trace, ID and retire ports of the trace dispatcher.
interface reorder_trace_dispatcher_if
  import reorder_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_D,
  parameter int unsigned NUM_QUEUES = NUM_QUEUES_D,
  parameter int unsigned DEPTH      = DEPTH_D,
  parameter int unsigned MAX_SEG    = MAX_SEG_D
);
  localparam int unsigned SEL_W = clog2(NUM_QUEUES);
  localparam int unsigned ID_W  = clog2(DEPTH);
  localparam int unsigned LEN_W = clog2(MAX_SEG);

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ*LEN_W-1:0]         req_len_i;
  logic [NUM_REQ*MAX_SEG*SEL_W-1:0] req_sel_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [ID_W-1:0]                  grant_id_o;
  logic                             rl_full_i;
  logic                             trace_push_o;
  logic [SEL_W-1:0]                 trace_sel_o;
  logic                             trace_break_o;
  logic                             trace_id_push_o;
  logic [ID_W-1:0]                  trace_id_value_o;
  logic                             commit_id_valid_i;
  logic [ID_W-1:0]                  commit_id_value_i;
  logic                             commit_id_pull_o;
  logic                             retire_valid_o;
  logic [ID_W-1:0]                  retire_id_o;
  logic                             retire_ready_i;

  modport slave (
    input  req_valid_i, req_len_i, req_sel_i, rl_full_i,
           commit_id_valid_i, commit_id_value_i, retire_ready_i,
    output req_ready_o, grant_id_o, trace_push_o, trace_sel_o, trace_break_o,
           trace_id_push_o, trace_id_value_o, commit_id_pull_o,
           retire_valid_o, retire_id_o
  );

  modport master (
    output req_valid_i, req_len_i, req_sel_i, rl_full_i,
           commit_id_valid_i, commit_id_value_i, retire_ready_i,
    input  req_ready_o, grant_id_o, trace_push_o, trace_sel_o, trace_break_o,
           trace_id_push_o, trace_id_value_o, commit_id_pull_o,
           retire_valid_o, retire_id_o
  );

endinterface

// File: rtl/reorder_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or above ptr, wrapping.
module reorder_rr_arbiter
  import reorder_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = (32'(ptr) + i) % N;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_trace_dispatcher.sv
// Round-robin trace scheduler: grants a requester, streams its segments into
// the reorder logic, and tracks the ID space as committed IDs retire.
module reorder_trace_dispatcher
  import reorder_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_D,
  parameter int unsigned NUM_QUEUES = NUM_QUEUES_D,
  parameter int unsigned DEPTH      = DEPTH_D,
  parameter int unsigned MAX_SEG    = MAX_SEG_D
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  reorder_trace_dispatcher_if.slave  bus
);

  localparam int unsigned SEL_W  = clog2(NUM_QUEUES);
  localparam int unsigned ID_W   = clog2(DEPTH);
  localparam int unsigned LEN_W  = clog2(MAX_SEG);
  localparam int unsigned RR_W   = clog2(NUM_REQ);
  localparam int unsigned CNT_W  = ID_W + 1;
  localparam int unsigned SEGS_W = MAX_SEG * SEL_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [RR_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_next_id;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_outstanding;
  logic [LEN_W-1:0]   r_seg_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [SEGS_W-1:0]  r_sel;

  logic [NUM_REQ-1:0] w_gnt;
  logic [RR_W-1:0]    w_gnt_idx;
  logic               w_grant;
  logic               w_push;
  logic               w_last;
  logic               w_alloc;
  logic               w_pull;

  reorder_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (bus.req_valid_i),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gnt_idx = RR_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and trace/grant outputs; everything is gated while in reset
  always_comb begin
    w_state_nxt          = r_state;
    w_grant              = 1'b0;
    w_push               = 1'b0;
    w_last               = (r_seg_cnt == r_len);
    bus.req_ready_o      = '0;
    bus.grant_id_o       = '0;
    bus.trace_push_o     = 1'b0;
    bus.trace_sel_o      = '0;
    bus.trace_break_o    = 1'b0;
    bus.trace_id_push_o  = 1'b0;
    bus.trace_id_value_o = '0;
    case (r_state)
      IDLE: begin
        if (!rst_i && (|bus.req_valid_i) && (r_outstanding < CNT_W'(DEPTH))
            && !bus.rl_full_i) begin
          w_grant         = 1'b1;
          w_state_nxt     = ISSUE;
          bus.req_ready_o = w_gnt;
          bus.grant_id_o  = r_next_id;
        end
      end
      ISSUE: begin
        if (!rst_i && !bus.rl_full_i) begin
          w_push            = 1'b1;
          bus.trace_push_o  = 1'b1;
          bus.trace_sel_o   = r_sel[32'(r_seg_cnt)*SEL_W +: SEL_W];
          bus.trace_break_o = w_last;
          if (w_last) begin
            bus.trace_id_push_o  = 1'b1;
            bus.trace_id_value_o = r_id;
            w_state_nxt          = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Retire path is a pass-through; a pull frees one ID
  always_comb begin
    w_pull               = bus.commit_id_valid_i & bus.retire_ready_i;
    w_alloc              = w_push & w_last;
    bus.retire_valid_o   = bus.commit_id_valid_i;
    bus.retire_id_o      = bus.commit_id_value_i;
    bus.commit_id_pull_o = w_pull;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr      <= '0;
      r_next_id     <= '0;
      r_id          <= '0;
      r_outstanding <= '0;
      r_seg_cnt     <= '0;
      r_len         <= '0;
      r_sel         <= '0;
    end else begin
      if (w_grant) begin
        r_len     <= bus.req_len_i[32'(w_gnt_idx)*LEN_W +: LEN_W];
        r_sel     <= bus.req_sel_i[32'(w_gnt_idx)*SEGS_W +: SEGS_W];
        r_id      <= r_next_id;
        r_seg_cnt <= '0;
        r_rr_ptr  <= (w_gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_push) r_seg_cnt <= r_seg_cnt + 1'b1;
      if (w_alloc) begin
        r_next_id <= (r_next_id == ID_W'(DEPTH - 1)) ? '0 : r_next_id + 1'b1;
      end
      case ({w_alloc, w_pull})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_trace_dispatcher.sv
// Randomized scoreboard bench for reorder_trace_dispatcher with a queue-based
// model of requesters, trace segments and the ID pool.
module tb_reorder_trace_dispatcher;
  import reorder_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NQ = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned MS = 4;
  localparam int unsigned SW = clog2(NQ);
  localparam int unsigned IW = clog2(DP);
  localparam int unsigned LW = clog2(MS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_trace_dispatcher_if #(.NUM_REQ(NR), .NUM_QUEUES(NQ), .DEPTH(DP), .MAX_SEG(MS)) bus ();

  reorder_trace_dispatcher #(.NUM_REQ(NR), .NUM_QUEUES(NQ), .DEPTH(DP), .MAX_SEG(MS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          brk;
    logic          idp;
    logic [IW-1:0] id;
  } seg_t;

  seg_t        exp_q[$];
  int unsigned alloc_q[$];
  bit          m_valid[NR];
  int unsigned m_len[NR];
  int unsigned m_sel[NR][MS];
  int unsigned rr_next;
  int unsigned grants;
  int unsigned outstanding;
  bit          issue_cyc;
  int          checks = 0;
  int          errors = 0;
  int unsigned retire_pct = 50;
  int unsigned full_pct   = 25;
  int unsigned new_pct    = 40;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int unsigned r = 0; r < NR; r++) begin
      if (!m_valid[r] && $urandom_range(0, 99) < new_pct) begin
        m_valid[r] = 1'b1;
        m_len[r]   = $urandom_range(0, MS - 1);
        for (int unsigned k = 0; k < MS; k++) m_sel[r][k] = $urandom_range(0, NQ - 1);
      end
      bus.req_valid_i[r]             = m_valid[r];
      bus.req_len_i[r*LW +: LW]      = LW'(m_len[r]);
      for (int unsigned k = 0; k < MS; k++)
        bus.req_sel_i[(r*MS+k)*SW +: SW] = SW'(m_sel[r][k]);
    end
    bus.rl_full_i = ($urandom_range(0, 99) < full_pct);
    if (!rst && alloc_q.size() > 0 && $urandom_range(0, 99) < 60) begin
      bus.commit_id_valid_i = 1'b1;
      bus.commit_id_value_i = IW'(alloc_q[0]);
    end else begin
      bus.commit_id_valid_i = 1'b0;
      bus.commit_id_value_i = IW'($urandom_range(0, DP - 1));
    end
    bus.retire_ready_i = ($urandom_range(0, 99) < retire_pct);
  endtask

  // Trace monitor: each push must match the next expected segment
  initial begin
    seg_t s;
    forever begin
      @(negedge clk);
      issue_cyc = (exp_q.size() != 0);
      if (rst) begin
        chk("push_in_reset", bus.trace_push_o, 0);
        chk("id_push_in_reset", bus.trace_id_push_o, 0);
        exp_q.delete();
      end else begin
        chk("trace_push", bus.trace_push_o, longint'(issue_cyc && !bus.rl_full_i));
        if (bus.trace_push_o && exp_q.size() != 0) begin
          s = exp_q.pop_front();
          chk("trace_sel", bus.trace_sel_o, s.sel);
          chk("trace_break", bus.trace_break_o, s.brk);
          chk("trace_id_push", bus.trace_id_push_o, s.idp);
          if (s.idp) begin
            chk("trace_id_value", bus.trace_id_value_o, s.id);
            outstanding++;
            alloc_q.push_back(32'(s.id));
          end
        end else begin
          chk("id_push_without_push", bus.trace_id_push_o, 0);
        end
      end
    end
  end

  // Grant and retire monitor, evaluated after the trace monitor each cycle
  initial begin
    logic [NR-1:0] exp_ready;
    int            win;
    bit            pull;
    int unsigned   len;
    forever begin
      @(negedge clk);
      #2;
      pull = bus.commit_id_valid_i && bus.retire_ready_i;
      chk("retire_valid", bus.retire_valid_o, bus.commit_id_valid_i);
      chk("commit_pull", bus.commit_id_pull_o, longint'(pull));
      if (bus.commit_id_valid_i && alloc_q.size() != 0)
        chk("retire_id_oldest", bus.retire_id_o, alloc_q[0]);
      if (rst) begin
        chk("ready_in_reset", bus.req_ready_o, 0);
        chk("grant_id_in_reset", bus.grant_id_o, 0);
        grants      = 0;
        rr_next     = 0;
        outstanding = 0;
        alloc_q.delete();
      end else begin
        exp_ready = '0;
        win       = -1;
        if (!issue_cyc && outstanding < DP && !bus.rl_full_i) begin
          for (int unsigned i = 0; i < NR; i++)
            if (win < 0 && m_valid[(rr_next + i) % NR]) win = int'((rr_next + i) % NR);
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", bus.req_ready_o, exp_ready);
        if (win >= 0) begin
          chk("grant_id", bus.grant_id_o, grants % DP);
          len = m_len[win];
          for (int unsigned k = 0; k <= len; k++)
            exp_q.push_back('{sel: SW'(m_sel[win][k]), brk: (k == len), idp: (k == len),
                              id: IW'(grants % DP)});
          grants++;
          rr_next      = (int'(win) + 1) % NR;
          m_valid[win] = 1'b0;
        end
        if (pull && alloc_q.size() != 0) begin
          void'(alloc_q.pop_front());
          outstanding--;
        end
      end
    end
  end

  initial begin
    bit seen;
    for (int unsigned r = 0; r < NR; r++) m_valid[r] = 1'b0;
    rst = 1'b1;
    drive_inputs();
    repeat (3) begin
      @(posedge clk); #1;
      drive_inputs();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_inputs();
    // Scarce retires keep the ID pool exhausted most of the time
    retire_pct = 10;
    repeat (400) begin
      @(posedge clk); #1;
      drive_inputs();
    end
    retire_pct = 60;
    full_pct   = 15;
    new_pct    = 70;
    repeat (600) begin
      @(posedge clk); #1;
      drive_inputs();
    end
    // Reset while a trace is being issued, then all requesters contend
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) seen = 1'b1;
      else drive_inputs();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL reset_mid_issue: got no issuing trace expected one within 300 cycles");
    end
    rst = 1'b1;
    drive_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int unsigned r = 0; r < NR; r++) begin
      m_valid[r] = 1'b1;
      m_len[r]   = 0;
    end
    full_pct = 0;
    drive_inputs();
    full_pct = 20;
    repeat (200) begin
      @(posedge clk); #1;
      drive_inputs();
    end
    @(negedge clk); #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
